// File: rtl/vga_sync_decoder.sv
// Purpose : recovers pixel coordinates and colour from a 640x480 VGA hsync/vsync/rgb stream and verifies its timing.
// Latency : 2 clocks from an rgb sample on the input pins to pix_rgb/pix_x/pix_y/pix_valid.
// Backpressure: none; the raster arrives at pixel rate and every output is produced every clock.
//
// Ports:
//   clk, rst               pixel clock, synchronous active-high reset
//   hsync, vsync, rgb      raw sync (active-low) and colour from the source
//   pix_valid/x/y/rgb      registered visible-pixel outputs, zero outside the visible area or while unlocked
//   frame_start            one-clock pulse alongside pixel (0,0)
//   locked, err_cnt        timing lock indicator and saturating count of lock losses
module vga_sync_decoder #(
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_VIS_START = 144,
   parameter int H_VIS_END   = 783,
   parameter int V_TOTAL     = 525,
   parameter int V_VIS_START = 35,
   parameter int V_VIS_END   = 514
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hsync,
   input  logic       vsync,
   input  logic [2:0] rgb,
   output logic       pix_valid,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic [2:0] pix_rgb,
   output logic       frame_start,
   output logic       locked,
   output logic [7:0] err_cnt
);

   localparam logic [9:0]  CNT_MAX = 10'h3FF;
   localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  H_PW    = 10'(H_SYNC);
   localparam logic [9:0]  H_VS    = 10'(H_VIS_START);
   localparam logic [9:0]  H_VE    = 10'(H_VIS_END);
   localparam logic [9:0]  V_VS    = 10'(V_VIS_START);
   localparam logic [9:0]  V_VE    = 10'(V_VIS_END);
   localparam logic [10:0] V_LINES = 11'(V_TOTAL);

   localparam logic [1:0] ST_UNLOCKED = 2'd0;
   localparam logic [1:0] ST_ACQUIRE  = 2'd1;
   localparam logic [1:0] ST_LOCKED   = 2'd2;

   // input stage and one delayed copy of the syncs for edge detection
   logic       hs_r, vs_r, hs_d, vs_d;
   logic [2:0] rgb_r;

   logic [9:0] h_cnt, v_cnt, pw_cnt;
   logic       pw_bad;
   logic [1:0] state, good_frames;

   logic        h_edge, v_edge, h_rise;
   logic        line_good, frame_good, line_bad, frame_bad, h_timeout;
   logic        h_vis, v_vis, vis;
   logic [10:0] frame_lines;

   assign h_edge = hs_d & ~hs_r;
   assign v_edge = vs_d & ~vs_r;
   assign h_rise = ~hs_d & hs_r;

   // v_cnt counts h_edges after the previous v_edge; a coincident h_edge belongs to the frame now ending
   assign frame_lines = {1'b0, v_cnt} + {10'd0, h_edge};
   assign line_good   = (h_cnt == H_LAST) && !pw_bad;
   assign frame_good  = (frame_lines == V_LINES);
   assign line_bad    = h_edge && !line_good;
   assign frame_bad   = v_edge && !frame_good;
   assign h_timeout   = (h_cnt == CNT_MAX);

   assign h_vis  = (h_cnt >= H_VS) && (h_cnt <= H_VE);
   assign v_vis  = (v_cnt >= V_VS) && (v_cnt <= V_VE);
   assign locked = (state == ST_LOCKED);
   assign vis    = locked && h_vis && v_vis;

   // syncs reset to their inactive level so no edge is seen on the first clock out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_r  <= 1'b1;
         vs_r  <= 1'b1;
         hs_d  <= 1'b1;
         vs_d  <= 1'b1;
         rgb_r <= 3'd0;
      end else begin
         hs_r  <= hsync;
         vs_r  <= vsync;
         hs_d  <= hs_r;
         vs_d  <= vs_r;
         rgb_r <= rgb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt  <= 10'd0;
         v_cnt  <= 10'd0;
         pw_cnt <= 10'd0;
         pw_bad <= 1'b0;
      end else begin
         if (h_edge)
            h_cnt <= 10'd0;
         else if (h_cnt != CNT_MAX)
            h_cnt <= h_cnt + 10'd1;

         if (v_edge)
            v_cnt <= 10'd0;
         else if (h_edge && (v_cnt != CNT_MAX))
            v_cnt <= v_cnt + 10'd1;

         // pw_cnt holds the number of low clocks so far, starting at 1 on the falling edge
         if (h_edge)
            pw_cnt <= 10'd1;
         else if (!hs_r && (pw_cnt != CNT_MAX))
            pw_cnt <= pw_cnt + 10'd1;

         // the line is judged at the h_edge using pw_bad, then the flag starts afresh
         if (h_edge)
            pw_bad <= 1'b0;
         else if (h_rise && (pw_cnt != H_PW))
            pw_bad <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_UNLOCKED;
         good_frames <= 2'd0;
         err_cnt     <= 8'd0;
      end else begin
         case (state)
            ST_UNLOCKED: begin
               if (v_edge) begin
                  state       <= ST_ACQUIRE;
                  good_frames <= 2'd0;
               end
            end
            ST_ACQUIRE: begin
               if (line_bad || frame_bad) begin
                  state <= ST_UNLOCKED;
               end else if (v_edge) begin
                  // second good frame in a row completes acquisition
                  if (good_frames == 2'd1)
                     state <= ST_LOCKED;
                  good_frames <= good_frames + 2'd1;
               end
            end
            ST_LOCKED: begin
               if (line_bad || frame_bad || h_timeout) begin
                  state <= ST_UNLOCKED;
                  if (err_cnt != 8'hFF)
                     err_cnt <= err_cnt + 8'd1;
               end
            end
            default: state <= ST_UNLOCKED;
         endcase
      end
   end

   // uses the current state, so pix_valid falls one clock after locked does
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_valid   <= 1'b0;
         pix_x       <= 10'd0;
         pix_y       <= 10'd0;
         pix_rgb     <= 3'd0;
         frame_start <= 1'b0;
      end else begin
         pix_valid   <= vis;
         pix_x       <= vis ? (h_cnt - H_VS) : 10'd0;
         pix_y       <= vis ? (v_cnt - V_VS) : 10'd0;
         pix_rgb     <= vis ? rgb_r : 3'd0;
         frame_start <= vis && (h_cnt == H_VS) && (v_cnt == V_VS);
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
module tb_vga_sync_decoder;

   // Reduced raster: same structure as 640x480, but a frame is only a few hundred clocks.
   localparam int H_TOTAL = 40;
   localparam int H_SYNC  = 6;
   localparam int H_VS    = 10;
   localparam int H_VE    = 33;
   localparam int V_TOTAL = 16;
   localparam int V_SYNC  = 2;
   localparam int V_VS    = 3;
   localparam int V_VE    = 12;
   localparam int H_VIS   = H_VE - H_VS + 1;
   localparam int V_VIS   = V_VE - V_VS + 1;
   localparam int MAXC    = 1023;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hsync = 1'b1;
   logic       vsync = 1'b1;
   logic [2:0] rgb = 3'd0;
   logic       pix_valid, frame_start, locked;
   logic [9:0] pix_x, pix_y;
   logic [2:0] pix_rgb;
   logic [7:0] err_cnt;

   vga_sync_decoder #(
      .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_VIS_START(H_VS), .H_VIS_END(H_VE),
      .V_TOTAL(V_TOTAL), .V_VIS_START(V_VS), .V_VIS_END(V_VE)
   ) dut (
      .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit valid; int x; int y; int rgb; bit fs; bit locked; int err;
   } exp_t;

   exp_t sb_q[$];
   exp_t pending;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_idx = 0;
   int   mon_idx = 0;
   int   lock_rise_idx = -1;
   int   vf_idx[$];
   int   valid_cnt = 0;
   int   fs_cnt = 0;
   bit   col_mode = 1'b1;

   // reference model: timestamps of sync events rather than counters
   bit m_prev_h, m_prev_v, m_pw_bad;
   int m_t_hfall, m_lines_v, m_st, m_good, m_err;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t zero_exp();
      exp_t e;
      e.valid = 0; e.x = 0; e.y = 0; e.rgb = 0; e.fs = 0; e.locked = 0; e.err = 0;
      return e;
   endfunction

   task automatic model_reset(input int t);
      m_prev_h = 1; m_prev_v = 1; m_pw_bad = 0;
      m_t_hfall = t - 1;   // line position restarts at 0 on the reset edge
      m_lines_v = 0; m_st = 0; m_good = 0; m_err = 0;
   endtask

   // sample t: pixel fields describe the output two clocks after the sample,
   // locked/err describe the state after the events seen in this sample
   task automatic model_step(input int t, input bit h, input bit v, input logic [2:0] c, output exp_t e);
      int hpos, line_no;
      bit hf, hr, vf, lg, fg, bad, vis;
      hpos = t - m_t_hfall - 1;
      if (hpos > MAXC) hpos = MAXC;
      line_no = m_lines_v;
      vis = (m_st == 2) && hpos >= H_VS && hpos <= H_VE && line_no >= V_VS && line_no <= V_VE;
      e.valid = vis;
      e.x     = vis ? hpos - H_VS : 0;
      e.y     = vis ? line_no - V_VS : 0;
      e.rgb   = vis ? int'(c) : 0;
      e.fs    = vis && hpos == H_VS && line_no == V_VS;
      hf = m_prev_h && !h;
      hr = !m_prev_h && h;
      vf = m_prev_v && !v;
      lg = (t - m_t_hfall == H_TOTAL) && !m_pw_bad;
      fg = (m_lines_v + (hf ? 1 : 0)) == V_TOTAL;
      bad = (hf && !lg) || (vf && !fg);
      case (m_st)
         0: if (vf) begin m_st = 1; m_good = 0; end
         1: if (bad) m_st = 0;
            else if (vf) begin m_good++; if (m_good == 2) m_st = 2; end
         default: if (bad || hpos == MAXC) begin m_st = 0; if (m_err < 255) m_err++; end
      endcase
      if (hr && (t - m_t_hfall) != H_SYNC) m_pw_bad = 1;
      if (hf) begin m_pw_bad = 0; m_t_hfall = t; end
      if (vf) m_lines_v = 0;
      else if (hf && m_lines_v < MAXC) m_lines_v++;
      m_prev_h = h;
      m_prev_v = v;
      e.locked = (m_st == 2);
      e.err    = m_err;
   endtask

   task automatic drive(input bit r, input bit h, input bit v, input logic [2:0] c);
      @(negedge clk);
      rst = r; hsync = h; vsync = v; rgb = c;
      if (r) begin
         sb_q.push_back(zero_exp());
         model_reset(edge_idx);
         pending = zero_exp();
         vf_idx.delete();
      end else begin
         sb_q.push_back(pending);
         if (m_prev_v && !v) vf_idx.push_back(edge_idx);
         model_step(edge_idx, h, v, c, pending);
      end
      edge_idx++;
   endtask

   task automatic run_frame(input int bad_line, input int extra, input int pw_line, input int pw_w,
                            input int rst_line, input int rst_col);
      int len, w, tmp;
      bit r;
      logic [2:0] px;
      for (int l = 0; l < V_TOTAL; l++) begin
         len = (l == bad_line) ? H_TOTAL + extra : H_TOTAL;
         w   = (l == pw_line) ? pw_w : H_SYNC;
         for (int c = 0; c < len; c++) begin
            tmp = c - 1 - H_VS;
            px  = col_mode ? tmp[2:0] : 3'($urandom);
            r   = (l == rst_line) && (c == rst_col);
            drive(r, c >= w, l >= V_SYNC, px);
            if (r) begin
               @(posedge clk); #1;
               check("rst_mid_valid", int'(pix_valid), 0);
               check("rst_mid_xy", int'(pix_x) + int'(pix_y), 0);
               check("rst_mid_rgb_fs", int'(pix_rgb) + int'(frame_start), 0);
               check("rst_mid_locked", int'(locked), 0);
               check("rst_mid_err", int'(err_cnt), 0);
            end
         end
      end
   endtask

   task automatic normal_frame();
      run_frame(-1, 0, -1, H_SYNC, -1, -1);
   endtask

   task automatic check_relock(input string name);
      int want;
      repeat (3) normal_frame();
      want = (vf_idx.size() >= 3) ? vf_idx[2] + 1 : -2;
      check(name, lock_rise_idx, want);
      check({name, "_locked"}, int'(locked), 1);
   endtask

   // monitor: one scoreboard entry per clock edge
   initial begin
      exp_t e;
      bit prev_locked = 0;
      forever begin
         @(posedge clk); #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (pix_valid != e.valid || int'(pix_x) != e.x || int'(pix_y) != e.y ||
                int'(pix_rgb) != e.rgb || frame_start != e.fs || locked != e.locked ||
                int'(err_cnt) != e.err) begin
               n_bad++;
               $display("FAIL sb edge %0d: got v=%0d x=%0d y=%0d rgb=%0d fs=%0d lk=%0d err=%0d, expected v=%0d x=%0d y=%0d rgb=%0d fs=%0d lk=%0d err=%0d",
                        mon_idx, pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_cnt,
                        e.valid, e.x, e.y, e.rgb, e.fs, e.locked, e.err);
            end
            if (col_mode && pix_valid) begin
               n_cmp++;
               if (pix_rgb != pix_x[2:0]) begin
                  n_bad++;
                  $display("FAIL col_rgb edge %0d: got %0d, expected %0d", mon_idx, pix_rgb, pix_x[2:0]);
               end
            end
            if (locked && !prev_locked) lock_rise_idx = mon_idx;
            prev_locked = locked;
            if (pix_valid) valid_cnt++;
            if (frame_start) fs_cnt++;
            mon_idx++;
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int bl;
      pending = zero_exp();
      repeat (3) drive(1, 1, 1, 3'd0);
      check("reset_locked", int'(locked), 0);
      check("reset_err", int'(err_cnt), 0);
      check("reset_valid", int'(pix_valid), 0);

      // acquisition on standard timing, column-coded colour
      col_mode = 1;
      repeat (3) normal_frame();
      check("lock_3rd_vedge", lock_rise_idx, (vf_idx.size() >= 3) ? vf_idx[2] + 1 : -2);
      check("locked_std", int'(locked), 1);
      check("err_std", int'(err_cnt), 0);

      valid_cnt = 0; fs_cnt = 0;
      normal_frame();
      check("pix_per_frame_col", valid_cnt, H_VIS * V_VIS);
      check("fs_per_frame_col", fs_cnt, 1);

      col_mode = 0;
      valid_cnt = 0; fs_cnt = 0;
      normal_frame();
      check("pix_per_frame_rnd", valid_cnt, H_VIS * V_VIS);
      check("fs_per_frame_rnd", fs_cnt, 1);

      // one line one clock too long
      bl = $urandom_range(V_VS + 1, V_VE - 1);
      run_frame(bl, 1, -1, H_SYNC, -1, -1);
      check("stretch_locked", int'(locked), 0);
      check("stretch_err", int'(err_cnt), 1);
      vf_idx.delete();
      check_relock("stretch_relock");

      // one hsync pulse one clock short
      bl = $urandom_range(V_VS + 1, V_VE - 1);
      run_frame(-1, 0, bl, H_SYNC - 1, -1, -1);
      check("narrow_locked", int'(locked), 0);
      check("narrow_err", int'(err_cnt), 2);
      vf_idx.delete();
      check_relock("narrow_relock");

      // hsync stuck high long enough for the line counter to saturate
      normal_frame();
      repeat (1100) drive(0, 1, 1, 3'($urandom));
      check("timeout_locked", int'(locked), 0);
      check("timeout_err", int'(err_cnt), 3);
      vf_idx.delete();
      check_relock("timeout_relock");

      // reset in the middle of the picture
      col_mode = 1;
      run_frame(-1, 0, -1, H_SYNC, V_VS + V_VIS / 2, H_VS + 1 + H_VIS / 2);
      check_relock("rst_relock");
      check("rst_relock_err", int'(err_cnt), 0);

      repeat (4) @(posedge clk);
      #1;
      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: pixel clock, one pixel per rising edge, the only clock.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port hsync, input, 1 bit: horizontal sync, active-low.
REQ-004 SHALL have port vsync, input, 1 bit: vertical sync, active-low.
REQ-005 SHALL have port rgb, input, 3 bits: pixel colour {R,G,B}.
REQ-006 SHALL have port pix_valid, output, 1 bit: pix_* outputs hold a visible pixel while locked.
REQ-007 SHALL have ports pix_x and pix_y, outputs, 10 bits each: column 0..639 and row 0..479.
REQ-008 SHALL have port pix_rgb, output, 3 bits: captured colour aligned with pix_x and pix_y.
REQ-009 SHALL have port frame_start, output, 1 bit: one-cycle pulse with pixel (0,0).
REQ-010 SHALL have port locked, output, 1 bit: timing verified against 640x480.
REQ-011 SHALL have port err_cnt, output, 8 bits: count of lock losses, saturating at 255.

Function
REQ-012 SHALL register hsync, vsync and rgb once on input.
REQ-013 SHALL define an h_edge as registered hsync going 1->0, and a v_edge likewise for vsync.
REQ-014 SHALL use fixed timing constants: H_TOTAL=800 and H_SYNC=96; visible h_cnt 144..783; V_TOTAL=525; visible v_cnt 35..514.
REQ-015 SHALL manage h_cnt (10 bits) as follows: set to 0 on an h_edge; otherwise increment, saturating at 1023.
REQ-016 SHALL manage v_cnt (10 bits) as follows: set to 0 on a v_edge, which has priority over a coincident h_edge; otherwise increment on an h_edge, saturating at 1023.
REQ-017 SHALL count hsync low-time in pw_cnt; on each hsync 0->1 it sets pw_bad if pw_cnt != 96.
REQ-018 SHALL judge a line good at an h_edge when h_cnt == 799 and pw_bad == 0; pw_bad then clears.
REQ-019 SHALL judge a frame good at a v_edge when the number of h_edges since the previous v_edge, including a coincident one, equals 525.
REQ-020 SHALL implement lock FSM transition UNLOCKED -> ACQUIRE on a v_edge, clearing good_frames.
REQ-021 SHALL, in ACQUIRE, go to UNLOCKED on a bad line or bad frame; each good frame increments good_frames; good_frames = 2 goes to LOCKED.
REQ-022 SHALL, in LOCKED, go to UNLOCKED and increment err_cnt (saturating) on a bad line, a bad frame, or h_cnt reaching 1023 (hsync timeout).
REQ-023 SHALL ignore line and frame checks while UNLOCKED.
REQ-024 SHALL drive locked = 1 exactly while the FSM is in LOCKED.
REQ-025 SHALL register all pix_* outputs, with latency of 2 clocks from an rgb input sample to pix_rgb.
REQ-026 SHALL set pix_valid = locked AND h_cnt in the visible range AND v_cnt in the visible range.
REQ-027 SHALL compute pix_x = h_cnt-144 and pix_y = v_cnt-35 when valid; otherwise pix_x, pix_y and pix_rgb are 0.
REQ-028 SHALL pulse frame_start in the same cycle as pix_valid with pix_x = 0 and pix_y = 0; the pulse occurs once per frame.
REQ-029 SHALL drop pix_valid in the cycle after locked deasserts.

Reset
REQ-030 SHALL, on rst = 1 at a clock edge, set FSM to UNLOCKED, h_cnt, v_cnt, pw_cnt, good_frames and pw_bad to 0, and the input registers to 1 (inactive, no spurious edge).
REQ-031 SHALL hold all outputs at 0 after reset, including err_cnt.
REQ-032 SHALL have rst override all other activity, including mid-frame.
REQ-033 SHALL reassert locked after reset no earlier than the third v_edge after reset.

Verification
REQ-034 SHALL be verified as follows: reset, then standard 800x525 timing with 96-clock hsync and 2-line vsync -> locked = 1 one clock after the 3rd v_edge; err_cnt = 0.
REQ-035 SHALL be verified as follows: locked, rgb = column[2:0] -> exactly 307200 pix_valid cycles per frame; pix_rgb = pix_x[2:0]; frame_start once per frame at (0,0); latency 2.
REQ-036 SHALL be verified as follows: locked, one line stretched to 801 clocks -> locked = 0 the clock after that h_edge; err_cnt = 1; pix_valid = 0; relock after 3 v_edges.
REQ-037 SHALL be verified as follows: locked, one hsync pulse 95 clocks wide -> lock lost at the next h_edge; err_cnt increments.
REQ-038 SHALL be verified as follows: locked, hsync held high for 1100 clocks -> locked = 0 when h_cnt hits 1023; err_cnt increments once.
REQ-039 SHALL be verified as follows: rst pulsed at pixel (320,240) -> next clock all outputs 0 and err_cnt = 0; relock at the 3rd subsequent v_edge.
